// File: rtl/mano_pkg.sv
// Shared definitions for the 8-bit Mano-style accumulator datapath:
// data width, 3-bit opcode codes and the sequencer state encoding.
package mano_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_CMA = 3'b011;
  localparam logic [2:0] OP_CLA = 3'b100;
  localparam logic [2:0] OP_CLE = 3'b101;
  localparam logic [2:0] OP_CME = 3'b110;
  localparam logic [2:0] OP_INC = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_LOAD = 3'd2,
    ST_EXEC = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Memory-reference instructions need an operand fetched into DR.
  function automatic logic is_mem_ref(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_ADD) || (op == OP_LDA);
  endfunction

  // Instructions whose EXEC step writes AC from the ALU result.
  function automatic logic writes_ac(input logic [2:0] op);
    return (op != OP_CLE) && (op != OP_CME);
  endfunction

endpackage

// File: rtl/ac_exec_ctrl.sv
// Sequencer and AC/DR/E register holder for the accumulator datapath.
// Fetches the memory operand into DR, drives the one-hot ALU selects in
// EXEC and latches the ALU result into AC and its carry into E.
module ac_exec_ctrl
  import mano_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          opcode,
  input  logic [ADDR_W-1:0]   addr,
  output logic                busy,
  output logic                done,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                alu_and,
  output logic                alu_add,
  output logic                alu_lda,
  output logic                alu_com,
  output logic [DATA_W-1:0]   ac,
  output logic [DATA_W-1:0]   dr,
  output logic                e,
  input  logic [DATA_W-1:0]   alu_acdata,
  input  logic                alu_carry
);

  state_t              state_q, state_d;
  logic [2:0]          opcode_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                mem_rd_q;
  logic                done_q;
  logic [DATA_W-1:0]   ac_q;
  logic [DATA_W-1:0]   dr_q;
  logic                e_q, e_d;
  logic                ac_we;

  // Next-state decode; start is only looked at while idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mem_ref(opcode)) begin
            state_d = ST_READ;
          end else if (opcode == OP_INC) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_READ: state_d = ST_LOAD;
      ST_LOAD: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus the registered read strobe and done pulse,
  // both derived from the state being entered so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mem_rd_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_rd_q <= (state_d == ST_READ);
      done_q   <= (state_d == ST_DONE);
    end
  end

  // Capture the instruction only when it is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q <= 3'b000;
      addr_q   <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      opcode_q <= opcode;
      addr_q   <= addr;
    end
  end

  // One-hot ALU selects, active only in EXEC. CLA/CLE/CME select nothing,
  // which makes the ALU present zero on ACDATA.
  always_comb begin
    alu_and = 1'b0;
    alu_add = 1'b0;
    alu_lda = 1'b0;
    alu_com = 1'b0;
    if (state_q == ST_EXEC) begin
      case (opcode_q)
        OP_AND:         alu_and = 1'b1;
        OP_ADD, OP_INC: alu_add = 1'b1;
        OP_LDA:         alu_lda = 1'b1;
        OP_CMA:         alu_com = 1'b1;
        default:        ;
      endcase
    end
  end

  // E update rule and AC write enable for the EXEC step.
  always_comb begin
    e_d   = e_q;
    ac_we = writes_ac(opcode_q);
    case (opcode_q)
      OP_ADD, OP_INC: e_d = alu_carry;
      OP_CLE:         e_d = 1'b0;
      OP_CME:         e_d = ~e_q;
      default:        e_d = e_q;
    endcase
  end

  // DR loads only in LOAD: the fetched operand, or the constant 1 for INC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dr_q <= '0;
    end else if (state_q == ST_LOAD) begin
      dr_q <= (opcode_q == OP_INC) ? 8'h01 : mem_rdata;
    end
  end

  // AC and E retire at the end of EXEC, so they are visible in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac_q <= '0;
      e_q  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      if (ac_we) begin
        ac_q <= alu_acdata;
      end
      e_q <= e_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = addr_q;
  assign ac       = ac_q;
  assign dr       = dr_q;
  assign e        = e_q;

endmodule

// File: tb/tb_ac_exec_ctrl.sv
// Directed bench for ac_exec_ctrl with a behavioural ALU and a
// one-cycle-latency memory model.
module tb_ac_exec_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] opcode;
  logic [7:0] addr;
  logic       busy, done, mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       alu_and, alu_add, alu_lda, alu_com;
  logic [7:0] ac, dr;
  logic       e;
  logic [7:0] alu_acdata;
  logic       alu_carry;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:255];

  ac_exec_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .addr(addr),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .alu_and(alu_and), .alu_add(alu_add),
    .alu_lda(alu_lda), .alu_com(alu_com), .ac(ac), .dr(dr), .e(e),
    .alu_acdata(alu_acdata), .alu_carry(alu_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers one cycle after the strobe; junk otherwise.
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 8'hEE;

  // Behavioural ALU.
  logic [8:0] sum9;
  assign sum9       = {1'b0, ac} + {1'b0, dr};
  assign alu_acdata = alu_and ? (ac & dr) : alu_add ? sum9[7:0] :
                      alu_lda ? dr : alu_com ? ~ac : 8'h00;
  assign alu_carry  = alu_add ? sum9[8] : 1'b0;

  // Issue one instruction and observe six cycles after the start edge.
  task automatic run_instr(input logic [2:0] op, input logic [7:0] a,
                           output int lat, output int nrd, output logic [7:0] rda,
                           output int n_and, output int n_add, output int n_lda,
                           output int n_com, output int ndone);
    lat = 0; nrd = 0; rda = 8'h00; n_and = 0; n_add = 0; n_lda = 0; n_com = 0; ndone = 0;
    @(negedge clk);
    start = 1'b1; opcode = op; addr = a;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (mem_rd) begin nrd++; rda = mem_addr; end
      n_and += int'(alu_and); n_add += int'(alu_add);
      n_lda += int'(alu_lda); n_com += int'(alu_com);
      if (done) begin ndone++; if (lat == 0) lat = cyc; end
      if (cyc < 6) @(negedge clk);
    end
    $display("instr op=%0d addr=%02h lat=%0d rd=%0d ac=%02h dr=%02h e=%0b",
             op, a, lat, nrd, ac, dr, e);
  endtask

  int lat, nrd, na, nd, nl, nc, ndn;
  logic [7:0] rda;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; opcode = 3'b000; addr = 8'h00;
    repeat (2) @(negedge clk);
    total++; if ({busy, done, mem_rd} !== 3'b000) begin bad++; $display("FAIL reset_ctrl got=%03b want=000", {busy, done, mem_rd}); end
    total++; if ({ac, dr, e} !== 17'h0) begin bad++; $display("FAIL reset_regs ac=%02h dr=%02h e=%0b want 0", ac, dr, e); end
    total++; if ({alu_and, alu_add, alu_lda, alu_com} !== 4'b0) begin bad++; $display("FAIL reset_sel got=%04b want=0000", {alu_and, alu_add, alu_lda, alu_com}); end
    total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL reset_maddr got=%02h want=00", mem_addr); end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_lda();
    mem[8'h10] = 8'h3C;
    run_instr(3'b010, 8'h10, lat, nrd, rda, na, nd, nl, nc, ndn);
    total++; if (nrd != 1) begin bad++; $display("FAIL lda_rdcount got=%0d want=1", nrd); end
    total++; if (rda !== 8'h10) begin bad++; $display("FAIL lda_maddr got=%02h want=10", rda); end
    total++; if (dr !== 8'h3C) begin bad++; $display("FAIL lda_dr got=%02h want=3c", dr); end
    total++; if (ac !== 8'h3C) begin bad++; $display("FAIL lda_ac got=%02h want=3c", ac); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL lda_e got=%0b want=0", e); end
    total++; if (lat != 4 || ndn != 1) begin bad++; $display("FAIL lda_done lat=%0d n=%0d want 4/1", lat, ndn); end
    total++; if (nl != 1 || na + nd + nc != 0) begin bad++; $display("FAIL lda_sel lda=%0d other=%0d want 1/0", nl, na + nd + nc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL lda_idle busy=%0b want=0", busy); end
  endtask

  task automatic test_add_carry();
    mem[8'h20] = 8'hF0; mem[8'h21] = 8'h20; mem[8'h22] = 8'h1F;
    run_instr(3'b010, 8'h20, lat, nrd, rda, na, nd, nl, nc, ndn);
    total++; if (ac !== 8'hF0) begin bad++; $display("FAIL add_pre_ac got=%02h want=f0", ac); end
    run_instr(3'b001, 8'h21, lat, nrd, rda, na, nd, nl, nc, ndn);
    total++; if (nd != 1 || na + nl + nc != 0) begin bad++; $display("FAIL add_sel add=%0d other=%0d want 1/0", nd, na + nl + nc); end
    total++; if (ac !== 8'h10) begin bad++; $display("FAIL add_ac got=%02h want=10", ac); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL add_e got=%0b want=1", e); end
    total++; if (lat != 4) begin bad++; $display("FAIL add_lat got=%0d want=4", lat); end
    run_instr(3'b000, 8'h22, lat, nrd, rda, na, nd, nl, nc, ndn);
    total++; if (ac !== 8'h10) begin bad++; $display("FAIL and_ac got=%02h want=10", ac); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL and_e got=%0b want=1", e); end
    total++; if (na != 1 || dr !== 8'h1F) begin bad++; $display("FAIL and_sel_dr and=%0d dr=%02h want 1/1f", na, dr); end
  endtask

  task automatic test_inc_wrap();
    mem[8'h30] = 8'hFF;
    run_instr(3'b101, 8'h00, lat, nrd, rda, na, nd, nl, nc, ndn);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL inc_pre_e got=%0b want=0", e); end
    run_instr(3'b010, 8'h30, lat, nrd, rda, na, nd, nl, nc, ndn);
    run_instr(3'b111, 8'h30, lat, nrd, rda, na, nd, nl, nc, ndn);
    total++; if (nrd != 0) begin bad++; $display("FAIL inc_rd got=%0d want=0", nrd); end
    total++; if (dr !== 8'h01) begin bad++; $display("FAIL inc_dr got=%02h want=01", dr); end
    total++; if (ac !== 8'h00) begin bad++; $display("FAIL inc_ac got=%02h want=00", ac); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL inc_e got=%0b want=1", e); end
    total++; if (lat != 3 || nd != 1) begin bad++; $display("FAIL inc_lat lat=%0d add=%0d want 3/1", lat, nd); end
  endtask

  task automatic test_reg_ref();
    mem[8'h40] = 8'h5A;
    run_instr(3'b101, 8'h00, lat, nrd, rda, na, nd, nl, nc, ndn);
    run_instr(3'b010, 8'h40, lat, nrd, rda, na, nd, nl, nc, ndn);
    run_instr(3'b011, 8'h00, lat, nrd, rda, na, nd, nl, nc, ndn);
    total++; if (ac !== 8'hA5 || nc != 1) begin bad++; $display("FAIL cma_ac got=%02h com=%0d want a5/1", ac, nc); end
    total++; if (lat != 2 || nrd != 0 || dr !== 8'h5A) begin bad++; $display("FAIL cma_timing lat=%0d rd=%0d dr=%02h want 2/0/5a", lat, nrd, dr); end
    run_instr(3'b110, 8'h00, lat, nrd, rda, na, nd, nl, nc, ndn);
    total++; if (e !== 1'b1 || ac !== 8'hA5) begin bad++; $display("FAIL cme e=%0b ac=%02h want 1/a5", e, ac); end
    total++; if (lat != 2 || dr !== 8'h5A || na + nd + nl + nc != 0) begin bad++; $display("FAIL cme_timing lat=%0d dr=%02h sel=%0d want 2/5a/0", lat, dr, na + nd + nl + nc); end
    run_instr(3'b101, 8'h00, lat, nrd, rda, na, nd, nl, nc, ndn);
    total++; if (e !== 1'b0 || lat != 2 || dr !== 8'h5A) begin bad++; $display("FAIL cle e=%0b lat=%0d dr=%02h want 0/2/5a", e, lat, dr); end
    run_instr(3'b100, 8'h00, lat, nrd, rda, na, nd, nl, nc, ndn);
    total++; if (ac !== 8'h00 || lat != 2 || dr !== 8'h5A) begin bad++; $display("FAIL cla ac=%02h lat=%0d dr=%02h want 00/2/5a", ac, lat, dr); end
  endtask

  task automatic test_busy_start();
    int ndone;
    mem[8'h50] = 8'h11; mem[8'h51] = 8'h22;
    run_instr(3'b010, 8'h50, lat, nrd, rda, na, nd, nl, nc, ndn);
    ndone = 0; nrd = 0;
    @(negedge clk); start = 1'b1; opcode = 3'b001; addr = 8'h51;
    @(negedge clk); start = 1'b1; opcode = 3'b100; addr = 8'h00;  // READ cycle
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (mem_rd) nrd++;
      if (done) ndone++;
      @(negedge clk);
      start = 1'b0;
    end
    $display("busy_start ac=%02h e=%0b done=%0d rd=%0d", ac, e, ndone, nrd);
    total++; if (ndone != 1) begin bad++; $display("FAIL busy_done got=%0d want=1", ndone); end
    total++; if (ac !== 8'h33 || e !== 1'b0) begin bad++; $display("FAIL busy_ac ac=%02h e=%0b want 33/0", ac, e); end
    total++; if (nrd != 1) begin bad++; $display("FAIL busy_rd got=%0d want=1", nrd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mask;
    mask = 8'h00;
    @(negedge clk); start = 1'b1; opcode = 3'b011; addr = 8'h00;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc == 5) start = 1'b0;
      if (done) mask[cyc] = 1'b1;
    end
    $display("back_to_back done_mask=%02h ac=%02h", mask, ac);
    total++; if (mask !== 8'h24) begin bad++; $display("FAIL b2b_done mask=%02h want=24", mask); end
    total++; if (ac !== 8'h33) begin bad++; $display("FAIL b2b_ac got=%02h want=33", ac); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    mem[8'h61] = 8'h99; mem[8'h62] = 8'hC3;
    ndone = 0;
    @(negedge clk); start = 1'b1; opcode = 3'b010; addr = 8'h61;
    @(negedge clk); start = 1'b0;                 // READ
    if (done) ndone++;
    @(negedge clk);                               // LOAD
    if (done) ndone++;
    rst = 1'b1;
    #1;
    total++; if ({busy, done, mem_rd} !== 3'b000) begin bad++; $display("FAIL rstmid_ctrl got=%03b want=000", {busy, done, mem_rd}); end
    total++; if ({ac, dr, e} !== 17'h0 || mem_addr !== 8'h00) begin bad++; $display("FAIL rstmid_regs ac=%02h dr=%02h e=%0b ma=%02h want 0", ac, dr, e, mem_addr); end
    total++; if ({alu_and, alu_add, alu_lda, alu_com} !== 4'b0) begin bad++; $display("FAIL rstmid_sel got=%04b want=0", {alu_and, alu_add, alu_lda, alu_com}); end
    repeat (2) begin @(negedge clk); if (done) ndone++; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (done) ndone++; end
    $display("reset_mid ac=%02h dr=%02h done=%0d", ac, dr, ndone);
    total++; if (ndone != 0 || ac !== 8'h00 || dr !== 8'h00) begin bad++; $display("FAIL rstmid_abort done=%0d ac=%02h dr=%02h want 0/00/00", ndone, ac, dr); end
    run_instr(3'b010, 8'h62, lat, nrd, rda, na, nd, nl, nc, ndn);
    total++; if (ac !== 8'hC3 || dr !== 8'hC3 || lat != 4 || nrd != 1) begin bad++; $display("FAIL rstmid_fresh ac=%02h dr=%02h lat=%0d rd=%0d want c3/c3/4/1", ac, dr, lat, nrd); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_lda();
    test_add_carry();
    test_inc_wrap();
    test_reg_ref();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ac_exec_ctrl.md
# ac_exec_ctrl

Sequencer and register holder for the accumulator datapath of the 8-bit Mano-style machine. It accepts one instruction at a time, fetches the memory operand into DR, and drives the one-hot operation selects of the combinational accumulator ALU. It then latches the ALU's result into AC and its carry into E. It sits directly upstream of the ALU and feeds its AND/ADD/LDA/COM, E, AC and DR inputs. It also sits directly downstream of the same ALU, consuming ACDATA and CARRY.

## Interface
- ADDR_W, 8, memory address width. The data width is fixed at 8 to match the ALU.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  instruction request; sampled only in IDLE.
- opcode  in  3  instruction code, captured with start.
- addr  in  ADDR_W  operand address, captured with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the instruction has retired.
- mem_rd  out  1  memory read strobe; exactly one cycle per memory-reference instruction.
- mem_addr  out  ADDR_W  the captured addr; valid while mem_rd is high.
- mem_rdata  in  8  read data, valid exactly one cycle after mem_rd.
- alu_and, alu_add, alu_lda, alu_com  out  1 each  ALU selects; at most one is high, and only in EXEC.
- ac  out  8  accumulator register, wired to the ALU AC input.
- dr  out  8  data register, wired to the ALU DR input.
- e  out  1  E flip-flop, wired to the ALU E input.
- alu_acdata  in  8  ALU result.
- alu_carry  in  1  ALU carry out of AC+DR.

## Operation
- Opcodes:
  - 000 AND: AC←AC&M.
  - 001 ADD: {E,AC}←AC+M.
  - 010 LDA: AC←M.
  - 011 CMA: AC←~AC.
  - 100 CLA: AC←0.
  - 101 CLE: E←0.
  - 110 CME: E←~E.
  - 111 INC: {E,AC}←AC+1.
- States: IDLE, READ, LOAD, EXEC, DONE.
- IDLE:
  - On start=1, capture opcode and addr.
  - Opcodes 000–010 go to READ.
  - INC goes to LOAD.
  - All others go to EXEC.
- READ: mem_rd=1, mem_addr=captured addr; go to LOAD.
- LOAD: DR←mem_rdata for opcodes 000–010; DR←8'h01 for INC. Go to EXEC.
- EXEC:
  - Selects are asserted as follows:
    - AND asserts alu_and.
    - ADD and INC assert alu_add.
    - LDA asserts alu_lda.
    - CMA asserts alu_com.
    - CLA, CLE and CME assert none.
  - AC←alu_acdata for every opcode except CLE and CME. CLA relies on ACDATA=0 when no select is asserted.
  - E updates per opcode:
    - ADD and INC: E←alu_carry.
    - CLE: E←0.
    - CME: E←~e.
    - All other opcodes: E holds.
  - Go to DONE.
- DONE: done=1; go to IDLE.
- start outside IDLE is ignored. It is neither queued nor captured.
- DR changes only in LOAD. CMA, CLA, CLE and CME leave DR unchanged.
- Arithmetic is 8-bit wrap. Carry comes only from the ALU; this block does no arithmetic.

## Timing
- Reset values: state=IDLE, ac=0, dr=0, e=0, busy=0, done=0, mem_rd=0, all selects=0, mem_addr=0.
- Latency from the start edge to the done pulse:
  - Memory-reference opcodes (000–010): 4 cycles (READ, LOAD, EXEC, DONE).
  - INC: 3 cycles.
  - CMA, CLA, CLE, CME: 2 cycles.
- New ac and e values are visible in the DONE cycle.
- Back-to-back operation: start may be held high continuously. The next instruction is accepted in the IDLE cycle that follows DONE, so there is a minimum 1-cycle IDLE gap between instructions.
- All outputs are registered, except that the selects and busy may be decoded from the state register.
- Reset asserted mid-instruction: the sequencer returns to IDLE immediately and the instruction is aborted.
  - No AC, E or DR write completes after reset.
  - No done pulse is issued.
  - mem_rd drops at once.

## Structure
- Shared package (mano_pkg) holds:
  - the 3-bit opcode localparams;
  - the state encoding typedef;
  - the data width constant (8).
- No sub-module. The ALU is instantiated beside this block in the parent, so the sequencer can be tested against a behavioural ALU model.

## Test plan
- LDA sequence:
  - Stimulus: reset; then start LDA, addr=8'h10, with memory returning 8'h3C.
  - Required response: mem_rd for exactly one cycle with mem_addr=8'h10; dr=8'h3C; ac=8'h3C; e=0; done on cycle 4.
- ADD with carry:
  - Stimulus: ac=8'hF0, ADD with M=8'h20.
  - Required response: alu_add high for exactly one cycle; ac=8'h10; e=1.
  - Follow-up: AND with M=8'h1F gives ac=8'h10, and e holds at 1.
- INC wrap:
  - Stimulus: ac=8'hFF, INC.
  - Required response: no mem_rd; dr=8'h01; ac=8'h00; e=1; done on cycle 3.
- Register-reference sequence:
  - Stimulus: CMA on ac=8'h5A, then CME, then CLE, then CLA.
  - Required responses, in order:
    - after CMA: ac=8'hA5;
    - after CME: e toggles;
    - after CLE: e=0;
    - after CLA: ac=8'h00.
  - Each instruction takes 2 cycles and leaves dr unchanged.
- start while busy:
  - Stimulus: pulse start with CLA during the READ state of an ADD.
  - Required response: the pulse is ignored; only the ADD retires, with exactly one done pulse.
- Reset mid-operation:
  - Stimulus: assert rst during the LOAD state of an LDA.
  - Required response: all outputs return to their reset values asynchronously; no done pulse.
  - After release, a fresh LDA completes normally.
